// File: rtl/mem_wb_if.sv
// MEM/WB stage bus: MEM-stage inputs and pipeline controls flow in,
// registered write-back controls and debug state flow out.
interface mem_wb_if #(
  parameter int RETIRE_W = 32
);
  logic                stall;
  logic                flush;
  logic                in_valid;
  logic [31:0]         alu_result;
  logic [31:0]         mem_rdata;
  logic [4:0]          rd_in;
  logic                reg_wr_in;
  logic                mem_to_reg_in;
  logic [2:0]          ld_type_in;
  logic                wb_valid;
  logic                wb_reg_wr;
  logic [4:0]          wb_rd;
  logic [31:0]         wb_data;
  logic                wb_adr_err;
  logic [31:0]         bad_addr;
  logic [RETIRE_W-1:0] retired;

  // Upstream side: drives the MEM-stage fields, observes write-back results.
  modport master (
    output stall, flush, in_valid, alu_result, mem_rdata, rd_in,
           reg_wr_in, mem_to_reg_in, ld_type_in,
    input  wb_valid, wb_reg_wr, wb_rd, wb_data, wb_adr_err, bad_addr, retired
  );

  // Stage side: consumes the MEM-stage fields, produces write-back results.
  modport slave (
    input  stall, flush, in_valid, alu_result, mem_rdata, rd_in,
           reg_wr_in, mem_to_reg_in, ld_type_in,
    output wb_valid, wb_reg_wr, wb_rd, wb_data, wb_adr_err, bad_addr, retired
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with big-endian load alignment, misaligned-load
// detection, a retired-instruction counter and a last-fault address register.
module mem_wb_stage #(
  parameter int RETIRE_W = 32
) (
  input logic     clk,
  input logic     rst_n,
  mem_wb_if.slave bus
);

  localparam logic [2:0] LD_LW  = 3'b000;
  localparam logic [2:0] LD_LB  = 3'b001;
  localparam logic [2:0] LD_LBU = 3'b010;
  localparam logic [2:0] LD_LH  = 3'b011;
  localparam logic [2:0] LD_LHU = 3'b100;

  localparam logic [RETIRE_W-1:0] RETIRE_ONE = {{(RETIRE_W-1){1'b0}}, 1'b1};

  // Extract and extend a load from a big-endian word; reserved types act as LW.
  function automatic logic [31:0] align_load(input logic [31:0] word,
                                             input logic [1:0]  off,
                                             input logic [2:0]  ty);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (off)
      2'b00:   b = word[31:24];
      2'b01:   b = word[23:16];
      2'b10:   b = word[15:8];
      2'b11:   b = word[7:0];
      default: b = 8'h00;
    endcase
    h = off[1] ? word[15:0] : word[31:16];
    case (ty)
      LD_LB:   res = {{24{b[7]}}, b};
      LD_LBU:  res = {24'h000000, b};
      LD_LH:   res = {{16{h[15]}}, h};
      LD_LHU:  res = {16'h0000, h};
      LD_LW:   res = word;
      default: res = word;
    endcase
    return res;
  endfunction

  // Alignment fault for a load: bytes never fault, halfwords need an even
  // address, words (and reserved types) need a word-aligned address.
  function automatic logic load_misaligned(input logic [1:0] off,
                                           input logic [2:0] ty);
    logic res;
    case (ty)
      LD_LB, LD_LBU: res = 1'b0;
      LD_LH, LD_LHU: res = off[0];
      default:       res = (off != 2'b00);
    endcase
    return res;
  endfunction

  logic                w_fault;
  logic [31:0]         w_sel_data;
  logic                w_capture;

  logic                r_valid;
  logic                r_reg_wr;
  logic [4:0]          r_rd;
  logic [31:0]         r_data;
  logic                r_adr_err;
  logic [31:0]         r_bad_addr;
  logic [RETIRE_W-1:0] r_retired;

  // Select write-back data and evaluate the fault; the ALU path never faults.
  always_comb begin
    w_fault    = 1'b0;
    w_sel_data = bus.alu_result;
    if (bus.mem_to_reg_in) begin
      w_fault    = load_misaligned(bus.alu_result[1:0], bus.ld_type_in);
      w_sel_data = align_load(bus.mem_rdata, bus.alu_result[1:0], bus.ld_type_in);
    end else begin
      w_fault    = 1'b0;
      w_sel_data = bus.alu_result;
    end
  end

  assign w_capture = !bus.stall && !bus.flush;

  // Stage registers: stall holds everything, flush kills the controls only,
  // otherwise capture the MEM-stage instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_reg_wr  <= 1'b0;
      r_rd      <= 5'd0;
      r_data    <= 32'h0000_0000;
      r_adr_err <= 1'b0;
    end else if (bus.stall) begin
      r_valid   <= r_valid;
      r_reg_wr  <= r_reg_wr;
      r_adr_err <= r_adr_err;
    end else if (bus.flush) begin
      r_valid   <= 1'b0;
      r_reg_wr  <= 1'b0;
      r_adr_err <= 1'b0;
    end else begin
      r_valid   <= bus.in_valid;
      r_rd      <= bus.rd_in;
      r_data    <= w_sel_data;
      r_adr_err <= bus.in_valid & w_fault;
      r_reg_wr  <= bus.in_valid & bus.reg_wr_in & (bus.rd_in != 5'd0) & !w_fault;
    end
  end

  // Debug state: latch the faulting address, count cleanly retired instructions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bad_addr <= 32'h0000_0000;
      r_retired  <= {RETIRE_W{1'b0}};
    end else if (w_capture && bus.in_valid) begin
      if (w_fault) begin
        r_bad_addr <= bus.alu_result;
      end else begin
        r_retired  <= r_retired + RETIRE_ONE;
      end
    end
  end

  assign bus.wb_valid   = r_valid;
  assign bus.wb_reg_wr  = r_reg_wr;
  assign bus.wb_rd      = r_rd;
  assign bus.wb_data    = r_data;
  assign bus.wb_adr_err = r_adr_err;
  assign bus.bad_addr   = r_bad_addr;
  assign bus.retired    = r_retired;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed scenarios with fixed
// expected values, then randomized traffic against a behavioural model.
module tb_mem_wb_stage;

  localparam int RW = 4;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  mem_wb_if #(.RETIRE_W(RW)) bus ();

  mem_wb_stage #(.RETIRE_W(RW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural expectation of the stage outputs.
  logic        m_valid;
  logic        m_reg_wr;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  logic        m_err;
  logic [31:0] m_bad;
  int          m_retired;

  // Big-endian load extraction from arithmetic on the address.
  function automatic logic [31:0] ref_load(input logic [31:0] word,
                                           input logic [31:0] addr,
                                           input logic [2:0]  ty);
    int          bpos;
    int          hpos;
    logic [7:0]  b;
    logic [15:0] h;
    int          sv;
    bpos = 8 * (3 - int'(addr % 32'd4));
    hpos = 16 * (1 - int'((addr / 32'd2) % 32'd2));
    b = 8'((word >> bpos) & 32'h0000_00FF);
    h = 16'((word >> hpos) & 32'h0000_FFFF);
    case (ty)
      3'd1:    begin sv = $signed(b); return sv; end
      3'd2:    return 32'(b);
      3'd3:    begin sv = $signed(h); return sv; end
      3'd4:    return 32'(h);
      default: return word;
    endcase
  endfunction

  // A load faults when the address is not a multiple of its access size.
  function automatic logic ref_fault(input logic [31:0] addr,
                                     input logic [2:0] ty, input logic m2r);
    int sz;
    if (ty == 3'd1 || ty == 3'd2) sz = 1;
    else if (ty == 3'd3 || ty == 3'd4) sz = 2;
    else sz = 4;
    return m2r && ((addr % 32'(sz)) != 32'd0);
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_reg_wr = 1'b0; m_rd = 5'd0; m_data = 32'd0;
    m_err = 1'b0; m_bad = 32'd0; m_retired = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_model();
    chk("wb_valid",   {31'd0, bus.wb_valid},   {31'd0, m_valid});
    chk("wb_reg_wr",  {31'd0, bus.wb_reg_wr},  {31'd0, m_reg_wr});
    chk("wb_rd",      {27'd0, bus.wb_rd},      {27'd0, m_rd});
    chk("wb_data",    bus.wb_data,             m_data);
    chk("wb_adr_err", {31'd0, bus.wb_adr_err}, {31'd0, m_err});
    chk("bad_addr",   bus.bad_addr,            m_bad);
    chk("retired",    32'(bus.retired),        32'(m_retired % (1 << RW)));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"},   {31'd0, bus.wb_valid},   32'd0);
    chk({tag, "_reg_wr"},  {31'd0, bus.wb_reg_wr},  32'd0);
    chk({tag, "_rd"},      {27'd0, bus.wb_rd},      32'd0);
    chk({tag, "_data"},    bus.wb_data,             32'd0);
    chk({tag, "_adr_err"}, {31'd0, bus.wb_adr_err}, 32'd0);
    chk({tag, "_bad"},     bus.bad_addr,            32'd0);
    chk({tag, "_retired"}, 32'(bus.retired),        32'd0);
  endtask

  // Drive one cycle of inputs, advance the model across the edge, compare.
  task automatic step(input logic st, input logic fl, input logic v,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic [4:0] rd, input logic rw, input logic m2r,
                      input logic [2:0] ty);
    logic f;
    bus.stall = st; bus.flush = fl; bus.in_valid = v; bus.alu_result = a;
    bus.mem_rdata = d; bus.rd_in = rd; bus.reg_wr_in = rw;
    bus.mem_to_reg_in = m2r; bus.ld_type_in = ty;
    @(posedge clk);
    f = ref_fault(a, ty, m2r);
    if (st) begin
      // everything holds
    end else if (fl) begin
      m_valid = 1'b0; m_reg_wr = 1'b0; m_err = 1'b0;
    end else begin
      m_valid  = v;
      m_rd     = rd;
      m_data   = m2r ? ref_load(d, a, ty) : a;
      m_err    = v && f;
      m_reg_wr = v && rw && (rd != 5'd0) && !f;
      if (v && f) m_bad = a;
      if (v && !f) m_retired = m_retired + 1;
    end
    #1;
    check_model();
  endtask

  // Hard stop so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    model_reset();
    rst_n = 1'b0;
    bus.stall = 1'b0; bus.flush = 1'b0; bus.in_valid = 1'b0;
    bus.alu_result = 32'd0; bus.mem_rdata = 32'd0; bus.rd_in = 5'd0;
    bus.reg_wr_in = 1'b0; bus.mem_to_reg_in = 1'b0; bus.ld_type_in = 3'd0;
    #2;
    check_zero("reset");
    #10;
    rst_n = 1'b1;

    // Byte loads: sign and zero extension.
    step(1'b0, 1'b0, 1'b1, 32'h104, 32'h80FF7F01, 5'd5, 1'b1, 1'b1, 3'd1);
    chk("lb_data", bus.wb_data, 32'hFFFFFF80);
    chk("lb_reg_wr", {31'd0, bus.wb_reg_wr}, 32'd1);
    chk("lb_rd", {27'd0, bus.wb_rd}, 32'd5);
    chk("lb_retired", 32'(bus.retired), 32'd1);
    step(1'b0, 1'b0, 1'b1, 32'h106, 32'h80FF7F01, 5'd5, 1'b1, 1'b1, 3'd2);
    chk("lbu_data", bus.wb_data, 32'h0000007F);

    // Halfword and word extraction.
    step(1'b0, 1'b0, 1'b1, 32'h102, 32'h1234ABCD, 5'd6, 1'b1, 1'b1, 3'd3);
    chk("lh_data", bus.wb_data, 32'hFFFFABCD);
    step(1'b0, 1'b0, 1'b1, 32'h102, 32'h1234ABCD, 5'd6, 1'b1, 1'b1, 3'd4);
    chk("lhu_data", bus.wb_data, 32'h0000ABCD);
    step(1'b0, 1'b0, 1'b1, 32'h100, 32'h1234ABCD, 5'd6, 1'b1, 1'b1, 3'd0);
    chk("lw_data", bus.wb_data, 32'h1234ABCD);

    // Misaligned word load, then an aligned one.
    step(1'b0, 1'b0, 1'b1, 32'h203, 32'h55AA55AA, 5'd7, 1'b1, 1'b1, 3'd0);
    chk("mis_err", {31'd0, bus.wb_adr_err}, 32'd1);
    chk("mis_reg_wr", {31'd0, bus.wb_reg_wr}, 32'd0);
    chk("mis_valid", {31'd0, bus.wb_valid}, 32'd1);
    chk("mis_bad", bus.bad_addr, 32'h203);
    chk("mis_retired", 32'(bus.retired), 32'd5);
    step(1'b0, 1'b0, 1'b1, 32'h200, 32'h55AA55AA, 5'd7, 1'b1, 1'b1, 3'd0);
    chk("aligned_err", {31'd0, bus.wb_adr_err}, 32'd0);
    chk("aligned_bad", bus.bad_addr, 32'h203);

    // ALU path to $0 at an odd address: no fault, no write, still retires.
    step(1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 32'h0, 5'd0, 1'b1, 1'b0, 3'd0);
    chk("alu_data", bus.wb_data, 32'hDEADBEEF);
    chk("alu_err", {31'd0, bus.wb_adr_err}, 32'd0);
    chk("alu_reg_wr", {31'd0, bus.wb_reg_wr}, 32'd0);
    chk("alu_retired", 32'(bus.retired), 32'd7);

    // Stall beats flush for three cycles, then flush alone.
    step(1'b0, 1'b0, 1'b1, 32'h300, 32'hCAFEF00D, 5'd3, 1'b1, 1'b1, 3'd0);
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b1, 1'b1, 32'h404, 32'h11111111, 5'd9, 1'b1, 1'b1, 3'd0);
    chk("stall_data", bus.wb_data, 32'hCAFEF00D);
    chk("stall_retired", 32'(bus.retired), 32'd8);
    step(1'b0, 1'b1, 1'b1, 32'h404, 32'h11111111, 5'd9, 1'b1, 1'b1, 3'd0);
    chk("flush_valid", {31'd0, bus.wb_valid}, 32'd0);
    chk("flush_data", bus.wb_data, 32'hCAFEF00D);

    // Asynchronous reset between edges while stalled and flushed.
    bus.stall = 1'b1; bus.flush = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    model_reset();
    #2;
    rst_n = 1'b1;

    // Counter wrap at four bits.
    for (int i = 1; i <= 17; i++) begin
      step(1'b0, 1'b0, 1'b1, 32'(i * 4), 32'h0, 5'd1, 1'b1, 1'b0, 3'd0);
      if (i == 15) chk("wrap_15", 32'(bus.retired), 32'hF);
      if (i == 16) chk("wrap_16", 32'(bus.retired), 32'h0);
      if (i == 17) chk("wrap_17", 32'(bus.retired), 32'h1);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 3) != 0, $urandom, $urandom,
           5'($urandom_range(0, 31)), 1'($urandom), $urandom_range(0, 3) != 0,
           3'($urandom_range(0, 7)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Pipeline register and load-alignment stage that sits directly downstream of the data memory. It captures the word-wide memory read data and the ALU result at the end of the MEM stage.
- It extracts and extends byte and halfword loads, detects misaligned load addresses, and presents registered write-back controls to the register file.
- It also provides a retired-instruction counter and a last-fault address register for debug.

Parameters:
- RETIRE_W, 32, width of the retired-instruction counter; the counter wraps modulo 2^RETIRE_W.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- stall  input  1  hold all stage registers.
- flush  input  1  insert a bubble.
- in_valid  input  1  MEM-stage instruction valid.
- alu_result  input  32  ALU result; this is the load/store address for memory ops.
- mem_rdata  input  32  combinational word read from data memory at alu_result[11:2].
- rd_in  input  5  destination register.
- reg_wr_in  input  1  instruction writes a register.
- mem_to_reg_in  input  1  1 = write-back from memory, 0 = from alu_result.
- ld_type_in  input  3  000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU; 101-111 are treated as LW.
- wb_valid  output  1  registered valid.
- wb_reg_wr  output  1  registered register-file write enable.
- wb_rd  output  5  registered destination register.
- wb_data  output  32  registered write-back data.
- wb_adr_err  output  1  registered misaligned-load flag for this instruction.
- bad_addr  output  32  address of the most recent misaligned load.
- retired  output  RETIRE_W  count of accepted, non-faulting instructions.

Behaviour:
- Reset (asynchronous, rst_n=0): every output and internal register is 0.
- Latency: one cycle. Inputs sampled at rising edge N appear on the outputs after edge N.
- Byte order is big-endian:
  - byte at addr[1:0]=00 is mem_rdata[31:24], 01 is [23:16], 10 is [15:8], 11 is [7:0].
  - halfword at addr[1]=0 is [31:16], addr[1]=1 is [15:0].
- Extraction, performed combinationally ahead of the register:
  - LB and LH sign-extend.
  - LBU and LHU zero-extend.
  - LW passes the word through.
- Misalignment (only when mem_to_reg_in=1):
  - LW and reserved types: fault if alu_result[1:0]!=0.
  - LH and LHU: fault if alu_result[0]!=0.
  - LB and LBU: never fault.
- Write-back data select: mem_to_reg_in=0 gives wb_data=alu_result; ld_type is ignored and no fault check is made.
- Register-update priority, evaluated at each rising edge:
  1. stall=1: all registers hold, including retired and bad_addr. Stall has priority over a simultaneous flush.
  2. flush=1: wb_valid=0, wb_reg_wr=0, wb_adr_err=0. wb_rd and wb_data hold their previous values. retired does not increment.
  3. Otherwise capture:
     - wb_valid <= in_valid.
     - wb_rd <= rd_in.
     - wb_data <= selected or extracted data.
     - wb_adr_err <= in_valid & fault.
     - wb_reg_wr <= in_valid & reg_wr_in & (rd_in!=0) & !fault.
- Register $0 protection: rd_in=0 never produces wb_reg_wr=1.
- bad_addr: loads alu_result on any capture with in_valid & fault. Otherwise holds.
- retired: increments by 1 on any capture with in_valid & !fault, and wraps from all-ones to 0.
- in_valid=0 capture: produces a bubble (wb_valid=0, wb_reg_wr=0). wb_data still updates and is don't-care.
- Reset mid-stall or mid-flush: reset wins immediately and asynchronously. Outputs return to 0 without waiting for a clock edge.
- Ordering against the memory's write: the data memory writes on the falling edge. A store followed by a load to the same word in the next cycle therefore reads the new data; this stage needs no bypass.

Test Plan:
- LB sign-extension: mem_rdata=0x80FF7F01, alu_result=0x104, LB, rd=5, reg_wr=1, mem_to_reg=1.
  - Next cycle: wb_data=0xFFFFFF80, wb_reg_wr=1, wb_rd=5, retired=1.
  - Same word with alu_result=0x106 and LBU: wb_data=0x0000007F.
- Halfword and word extraction:
  - mem_rdata=0x1234ABCD, alu_result=0x102, LH: wb_data=0xFFFFABCD.
  - Same inputs with LHU: wb_data=0x0000ABCD.
  - alu_result=0x100, LW: wb_data=0x1234ABCD.
- Misaligned LW at alu_result=0x203, rd=7:
  - wb_adr_err=1, wb_reg_wr=0, wb_valid=1, bad_addr=0x203, retired unchanged.
  - Following aligned LW: wb_adr_err=0, bad_addr still 0x203.
- ALU path and $0: mem_to_reg=0, alu_result=0xDEADBEEF, LW at an odd address, rd=0.
  - wb_data=0xDEADBEEF, wb_adr_err=0, wb_reg_wr=0, retired increments.
- Stall and flush:
  - Load a valid instruction, then assert stall=1 and flush=1 together for 3 cycles: outputs and retired hold.
  - Drop stall with flush=1: wb_valid=0, wb_reg_wr=0, wb_data holds.
  - Assert rst_n=0 asynchronously between clock edges: all outputs are 0 immediately.
- Counter wrap: RETIRE_W=4, issue 17 valid non-faulting instructions: retired reads 0xF after 15, then 0, then 1.
